// File: rtl/hd74hc165.sv
// rtl/hd74hc165.sv - parallel-in / serial-out shift register (74HC165 behaviour)
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset, clears the register
//   shift_load     0 = parallel load from q, 1 = shift / hold
//   clock_in_hibit 1 = hold the register while in shift mode
//   serial_in      cascade input, enters stage 0 on each shift
//   q              parallel word, q[WIDTH-1] is the stage nearest the output
//   qh             serial output, register bit WIDTH-1
//   qh_bar         complement of qh
module hd74hc165 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_load,
  input  logic             clock_in_hibit,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] q,
  output logic             qh,
  output logic             qh_bar
);

  logic [WIDTH-1:0] sr;

  // Load beats inhibit; inhibit only freezes shifting. The shift is written
  // as a left shift with the serial bit OR'd into stage 0 so WIDTH=1 is legal.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (!shift_load) begin
      sr <= q;
    end else if (!clock_in_hibit) begin
      sr <= (sr << 1) | WIDTH'(serial_in);
    end
  end

  assign qh     = sr[WIDTH-1];
  assign qh_bar = ~sr[WIDTH-1];

endmodule

// File: tb/tb_hd74hc165.sv
// tb/tb_hd74hc165.sv - self-checking bench for hd74hc165 against a bit-queue model
module tb_hd74hc165;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             shift_load;
  logic             clock_in_hibit;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             qh;
  logic             qh_bar;

  int n_assert;
  int n_fail;

  // Model: queue of bits in output order; element 0 is what qh shows.
  bit model_q[$];

  hd74hc165 #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .shift_load     (shift_load),
    .clock_in_hibit (clock_in_hibit),
    .serial_in      (serial_in),
    .q              (q),
    .qh             (qh),
    .qh_bar         (qh_bar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp_v);
    n_assert++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    for (int i = 0; i < WIDTH; i++) model_q.push_back(1'b0);
  endtask

  task automatic check_outputs(input string tag);
    check_bit({tag, " qh"}, qh, model_q[0]);
    check_bit({tag, " qh_bar"}, qh_bar, ~model_q[0]);
  endtask

  // Apply one set of inputs across one rising edge, update the model,
  // then compare just after the edge.
  task automatic cycle(input string tag, input logic sl, input logic inh,
                       input logic si, input logic [WIDTH-1:0] qv);
    shift_load     = sl;
    clock_in_hibit = inh;
    serial_in      = si;
    q              = qv;
    @(posedge clk);
    if (!sl) begin
      model_q.delete();
      for (int i = WIDTH - 1; i >= 0; i--) model_q.push_back(qv[i]);
    end else if (!inh) begin
      void'(model_q.pop_front());
      model_q.push_back(si);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs({tag, " async"});
    @(posedge clk);
    #1;
    check_outputs({tag, " held"});
    reset = 1'b0;
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    shift_load     = 1'b1;
    clock_in_hibit = 1'b0;
    serial_in      = 1'b1;
    q              = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset = 1'b0;

    // Serial fill with ones, then flush with zeros.
    for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 9; i++) cycle("flush", 1'b1, 1'b0, 1'b0, 8'h00);

    // Load 0xAA then shift zeros.
    cycle("load_aa", 1'b0, 1'b0, 1'b0, 8'hAA);
    for (int i = 0; i < 9; i++) cycle("shift_aa", 1'b1, 1'b0, 1'b0, 8'h00);

    // Inhibit with 0x0F loaded, then release.
    cycle("load_0f", 1'b0, 1'b0, 1'b0, 8'h0F);
    for (int i = 0; i < 8; i++) cycle("inhibit", 1'b1, 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 8; i++) cycle("release", 1'b1, 1'b0, 1'b0, 8'h00);

    // Load 0xCC then shift zeros.
    cycle("load_cc", 1'b0, 1'b0, 1'b0, 8'hCC);
    for (int i = 0; i < 9; i++) cycle("shift_cc", 1'b1, 1'b0, 1'b0, 8'h00);

    // Load takes priority over inhibit.
    cycle("load_vs_inh", 1'b0, 1'b1, 1'b0, 8'h80);

    // Reset in the middle of shifting discards the data.
    cycle("load_ff", 1'b0, 1'b0, 1'b1, 8'hFF);
    cycle("pre_rst", 1'b1, 1'b0, 1'b1, 8'h00);
    pulse_reset("mid_rst");
    for (int i = 0; i < 3; i++) cycle("post_rst", 1'b1, 1'b0, 1'b0, 8'h00);

    // Random mix of load / shift / hold with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        pulse_reset("rnd_rst");
      end else begin
        cycle("random",
              ($urandom_range(0, 5) != 0),
              ($urandom_range(0, 3) == 0),
              1'($urandom),
              WIDTH'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
